// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle divider: bus widths, FSM state encoding
// and the iteration count.
package divider_pkg;

    localparam int DataBus        = 32;
    localparam int DoubleDataBus  = 64;
    localparam int DIV_ITERATIONS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_t;

    // Magnitude of an operand; only signed operations take the absolute value.
    function automatic logic [DataBus-1:0] div_mag(input logic [DataBus-1:0] v, input logic en);
        return (en && v[DataBus-1]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration on the 65-bit
// {rem[32:0], quo[31:0]} working register.
module div_step
    import divider_pkg::*;
(
    input  logic [64:0]        i_work,
    input  logic [DataBus-1:0] i_divisor,
    output logic [64:0]        o_work
);

    logic [64:0] w_shift;
    logic [32:0] w_diff;

    // Shift, trial-subtract, and keep the difference only when it stays non-negative.
    always_comb begin
        w_shift = i_work << 7'd1;
        w_diff  = w_shift[64:32] - {1'b0, i_divisor};
        if (!w_diff[32]) begin
            o_work = {w_diff, w_shift[31:1], 1'b1};
        end else begin
            o_work = w_shift;
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle 32-bit DIV/DIVU unit. Build macro DIV_EARLY_OUT_EN finishes in
// one cycle when |dividend| < |divisor|.
module divider
    import divider_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cancel,
    input  logic                     is_signed,
    input  logic [DataBus-1:0]       operand_1,
    input  logic [DataBus-1:0]       operand_2,
    output logic                     ready,
    output logic [DoubleDataBus-1:0] div_res
);

    div_state_t               r_state;
    logic [5:0]               r_cnt;
    logic [64:0]              r_work;
    logic [DataBus-1:0]       r_divisor;
    logic                     r_neg_q;
    logic                     r_neg_r;
    logic                     r_ready;
    logic [DoubleDataBus-1:0] r_div_res;

    logic [64:0]              w_next_work;
    logic [DataBus-1:0]       w_mag_1;
    logic [DataBus-1:0]       w_mag_2;
    logic [DataBus-1:0]       w_quo_fix;
    logic [DataBus-1:0]       w_rem_fix;
    logic                     w_early;

    assign w_mag_1 = div_mag(operand_1, is_signed);
    assign w_mag_2 = div_mag(operand_2, is_signed);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (operand_2 != 32'd0) && (w_mag_1 < w_mag_2);
`else
    assign w_early = 1'b0;
`endif

    div_step u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_next_work)
    );

    // Sign correction of the final iteration: quotient by sign mismatch, remainder follows dividend.
    always_comb begin
        if (r_neg_q) begin
            w_quo_fix = 32'd0 - w_next_work[31:0];
        end else begin
            w_quo_fix = w_next_work[31:0];
        end
        if (r_neg_r) begin
            w_rem_fix = 32'd0 - w_next_work[63:32];
        end else begin
            w_rem_fix = w_next_work[63:32];
        end
    end

    // Control FSM, iteration counter, operand capture and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ready   <= 1'b0;
            r_div_res <= 64'd0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_ready <= 1'b0;
                    if (start && !cancel) begin
                        r_neg_q <= is_signed & (operand_1[31] ^ operand_2[31]);
                        r_neg_r <= is_signed & operand_1[31];
                        r_cnt   <= 6'd0;
                        if (operand_2 == 32'd0) begin
                            r_state <= DIV_ZERO;
                        end else if (w_early) begin
                            // Quotient is zero and the remainder is the untouched dividend.
                            r_state   <= DIV_END;
                            r_ready   <= 1'b1;
                            r_div_res <= {operand_1, 32'd0};
                        end else begin
                            r_state   <= DIV_ON;
                            r_work    <= {33'd0, w_mag_1};
                            r_divisor <= w_mag_2;
                        end
                    end
                end
                DIV_ZERO: begin
                    if (cancel) begin
                        r_state <= DIV_IDLE;
                        r_ready <= 1'b0;
                    end else begin
                        r_state   <= DIV_END;
                        r_ready   <= 1'b1;
                        r_div_res <= 64'd0;
                    end
                end
                DIV_ON: begin
                    if (cancel) begin
                        r_state <= DIV_IDLE;
                        r_cnt   <= 6'd0;
                        r_ready <= 1'b0;
                    end else begin
                        r_work <= w_next_work;
                        if (r_cnt == 6'(DIV_ITERATIONS - 1)) begin
                            r_state   <= DIV_END;
                            r_cnt     <= 6'd0;
                            r_ready   <= 1'b1;
                            r_div_res <= {w_rem_fix, w_quo_fix};
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                DIV_END: begin
                    r_state <= DIV_IDLE;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign div_res = r_div_res;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic        is_signed;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        ready;
    logic [63:0] div_res;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .is_signed (is_signed),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .ready     (ready),
        .div_res   (div_res)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {remainder, quotient} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges after the accepting edge until ready is seen high.
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 0;
`endif
        return (ma == mb) ? 32 : 32;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic hold);
        int  n;
        bit  seen;
        @(negedge clk);
        operand_1 = a;
        operand_2 = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (ready) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat(a, b, s)));
        chk({tag, "_result"}, div_res, model(a, b, s));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra, rb;
        logic        rs;
        int          seen_cnt;

        rst       = 1'b0;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        operand_1 = 32'd0;
        operand_2 = 32'd0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_res", div_res, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 1'b1);
        chk("u100_7_const", div_res, {32'h00000002, 32'h0000000E});
        run_op("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        chk("s-7_2_const", div_res, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
        chk("s7_-2_const", div_res, {32'h00000001, 32'hFFFFFFFD});
        run_op("s5_0", 32'd5, 32'd0, 1'b1, 1'b0);
        run_op("u5_0", 32'd5, 32'd0, 1'b0, 1'b0);
        chk("u5_0_const", div_res, 64'd0);
        run_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("s_ovf_const", div_res, {32'h00000000, 32'h80000000});
        run_op("u3_10", 32'd3, 32'd10, 1'b0, 1'b0);
        chk("u3_10_const", div_res, {32'h00000003, 32'h00000000});
        run_op("s-3_10", 32'hFFFFFFFD, 32'd10, 1'b1, 1'b0);
        prev = div_res;

        // Cancel in the middle of the iterations.
        @(negedge clk);
        operand_1 = 32'hFFFFFFFF;
        operand_2 = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen_cnt++;
        end
        chk("cancel_no_ready", 64'(seen_cnt), 64'd0);
        chk("cancel_res_kept", div_res, prev);
        run_op("u1000_10", 32'd1000, 32'd10, 1'b0, 1'b0);
        chk("u1000_10_const", div_res, {32'd0, 32'd100});

        // start together with cancel in IDLE is not accepted.
        @(negedge clk);
        operand_1 = 32'd50;
        operand_2 = 32'd0;
        start     = 1'b1;
        cancel    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen_cnt++;
        end
        chk("start_cancel_ignored", 64'(seen_cnt), 64'd0);
        chk("start_cancel_res", div_res, {32'd0, 32'd100});

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        operand_1 = 32'd12345;
        operand_2 = 32'd17;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_res", div_res, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen_cnt++;
        end
        chk("rst_no_ready", 64'(seen_cnt), 64'd0);

        // Randomized operations across both modes and divisor classes.
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = $urandom;
                default: rb = ra + 32'($urandom_range(1, 1000));
            endcase
            if (rs && $urandom_range(0, 1) == 1) rb = -rb;
            run_op($sformatf("rand%0d", k), ra, rb, rs, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
